// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller and the data-memory model.
// Holds the FSM state type, the SRAM data width, and the default CPU base address.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    localparam int          SRAM_W        = 16;
    localparam int unsigned BASE_ADDR_DEF = 32'd1024;

    // CPU byte address to SRAM word index; wraps in 32 bits below the base.
    function automatic logic [31:0] byte_to_word(input logic [31:0] addr,
                                                 input logic [31:0] base);
        logic [31:0] diff;
        diff = addr - base;
        return {2'b00, diff[31:2]};
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits a 32-bit load/store into two 16-bit accesses on an asynchronous SRAM,
// holding ready low until the full word has been transferred.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [SRAM_W-1:0] sram_dq_in,
    output logic [SRAM_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam int              CNT_W    = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    sram_state_e       state_r;
    sram_state_e       state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-2:0] word_r;
    logic [31:0]       wdata_r;
    logic              op_wr_r;
    logic [31:0]       read_data_r;
    logic [31:0]       word_s;
    logic              req_s;
    logic              last_s;
    logic              active_s;
    logic              half_s;
    logic              unused_word_s;

    assign req_s         = rd_en | wr_en;
    assign last_s        = (cnt_r == LAST_CNT);
    assign word_s        = byte_to_word(address, 32'(BASE_ADDR));
    assign unused_word_s = ^word_s[31:ADDR_W-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; each half ends on the last wait count
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_s = ST_LOW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (last_s) begin
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Wait counter restarts on every state change so each half gets WAIT_CYCLES cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_LOW) || (state_r == ST_HIGH)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Request latch; writes take priority when both enables are present
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r  <= {(ADDR_W-1){1'b0}};
            wdata_r <= 32'h0000_0000;
            op_wr_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            word_r  <= word_s[ADDR_W-2:0];
            wdata_r <= write_data;
            op_wr_r <= wr_en;
        end else begin
            word_r  <= word_r;
            wdata_r <= wdata_r;
            op_wr_r <= op_wr_r;
        end
    end

    // Read capture at the end of each half; stores leave read_data untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_r <= 32'h0000_0000;
        end else if (last_s && !op_wr_r) begin
            case (state_r)
                ST_LOW:  read_data_r[15:0]  <= sram_dq_in;
                ST_HIGH: read_data_r[31:16] <= sram_dq_in;
                default: read_data_r        <= read_data_r;
            endcase
        end else begin
            read_data_r <= read_data_r;
        end
    end

    // SRAM pins decoded from registered state only
    always_comb begin
        active_s    = (state_r == ST_LOW) || (state_r == ST_HIGH);
        half_s      = (state_r == ST_HIGH);
        sram_addr   = {word_r, half_s};
        sram_ce_n   = ~active_s;
        sram_ub_n   = ~active_s;
        sram_lb_n   = ~active_s;
        sram_oe_n   = ~(active_s & ~op_wr_r);
        sram_dq_oe  = active_s & op_wr_r;
        // we_n releases one cycle early so address and data are held past the write edge
        sram_we_n   = ~(active_s & op_wr_r & (cnt_r < LAST_CNT));
        sram_dq_out = 16'h0000;
        if (active_s && op_wr_r) begin
            if (half_s) begin
                sram_dq_out = wdata_r[31:16];
            end else begin
                sram_dq_out = wdata_r[15:0];
            end
        end else begin
            sram_dq_out = 16'h0000;
        end
    end

    // Pipeline stall control
    always_comb begin
        case (state_r)
            ST_DONE: ready = 1'b1;
            ST_IDLE: ready = ~req_s;
            default: ready = 1'b0;
        endcase
    end

    assign read_data = read_data_r;

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a small behavioural SRAM.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem [0:63];
    logic        mem_clr = 1'b1;
    logic        unused_addr;

    always #5 clk = ~clk;

    sram_controller #(.ADDR_W(18), .WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_in(sram_dq_in),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    assign unused_addr = ^sram_addr[17:6];
    assign sram_dq_in  = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0000;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            mem[sram_addr[5:0]] <= sram_dq_out;
        end
    end

    task automatic run_txn(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int stall, output int we_lo,
                           output int we_pulse, output int oe_lo, output int dqoe_hi,
                           output int cycles, output logic [31:0] rdata);
        logic prev_we;
        bit   done;
        stall = 0; we_lo = 0; we_pulse = 0; oe_lo = 0; dqoe_hi = 0; cycles = 0;
        rdata = 32'hxxxx_xxxx; prev_we = 1'b1; done = 1'b0;
        rd_en = r; wr_en = w; address = a; write_data = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            cycles++;
            if (ready) begin
                done  = 1'b1;
                rdata = read_data;
            end else begin
                stall++;
            end
            if (!sram_we_n) we_lo++;
            if (prev_we && !sram_we_n) we_pulse++;
            prev_we = sram_we_n;
            if (!sram_oe_n) oe_lo++;
            if (sram_dq_oe) dqoe_hi++;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL txn_timeout: ready never returned within 40 cycles (addr %0d)", a);
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if ({ready, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 7'b1111110) begin
            n_err++;
            $display("FAIL reset_strobes: got %b expected 1111110",
                     {ready, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe});
        end
        n_cmp++;
        if (read_data !== 32'h0 || sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin
            n_err++;
            $display("FAIL reset_values: read_data %h addr %h dq_out %h expected all 0",
                     read_data, sram_addr, sram_dq_out);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0;
    endtask

    task automatic test_idle;
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({ready, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 7'b1111110)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL idle_quiet: %0d of 10 cycles not quiet, expected 0", bad);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store;
        int st, wl, wp, ol, dq, cy;
        logic [31:0] rd;
        run_txn(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, st, wl, wp, ol, dq, cy, rd);
        n_cmp++;
        if (st != 5) begin n_err++; $display("FAIL store_stall: got %0d expected 5", st); end
        n_cmp++;
        if (wl != 2 || wp != 2) begin
            n_err++; $display("FAIL store_we: low %0d pulses %0d expected 2 and 2", wl, wp);
        end
        n_cmp++;
        if (dq != 4 || ol != 0) begin
            n_err++; $display("FAIL store_oe: dq_oe %0d oe_n low %0d expected 4 and 0", dq, ol);
        end
        n_cmp++;
        if (mem[4] !== 16'hBEEF || mem[5] !== 16'hDEAD) begin
            n_err++; $display("FAIL store_mem: got %h %h expected beef dead", mem[4], mem[5]);
        end
    endtask

    task automatic test_load;
        int st, wl, wp, ol, dq, cy;
        logic [31:0] rd;
        run_txn(1'b1, 1'b0, 32'd1032, 32'h0, st, wl, wp, ol, dq, cy, rd);
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_data: got %h expected deadbeef", rd); end
        n_cmp++;
        if (st != 5) begin n_err++; $display("FAIL load_stall: got %0d expected 5", st); end
        n_cmp++;
        if (ol != 4 || dq != 0 || wl != 0) begin
            n_err++; $display("FAIL load_strobes: oe_n low %0d dq_oe %0d we_n low %0d expected 4 0 0", ol, dq, wl);
        end
    endtask

    task automatic test_back_to_back;
        int st, wl, wp, ol, dq, cy1, cy2;
        logic [31:0] rd;
        run_txn(1'b0, 1'b1, 32'd1024, 32'h12345678, st, wl, wp, ol, dq, cy1, rd);
        run_txn(1'b1, 1'b0, 32'd1024, 32'h0, st, wl, wp, ol, dq, cy2, rd);
        n_cmp++;
        if (rd !== 32'h12345678) begin n_err++; $display("FAIL b2b_data: got %h expected 12345678", rd); end
        n_cmp++;
        if (cy1 + cy2 != 12) begin n_err++; $display("FAIL b2b_cycles: got %0d expected 12", cy1 + cy2); end
        n_cmp++;
        if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin
            n_err++; $display("FAIL b2b_mem: got %h %h expected 5678 1234", mem[0], mem[1]);
        end
    endtask

    task automatic test_reset_mid_load;
        int st, wl, wp, ol, dq, cy;
        logic [31:0] rd;
        rd_en = 1'b1; address = 32'd1032;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        n_cmp++;
        if (sram_oe_n !== 1'b0 || sram_addr !== 18'd5) begin
            n_err++; $display("FAIL midload_high: oe_n %b addr %0d expected 0 and 5", sram_oe_n, sram_addr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (read_data !== 32'h0 || sram_addr !== 18'd0 || ready !== 1'b0 ||
            {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
            n_err++;
            $display("FAIL midload_reset: read_data %h addr %0d ready %b strobes %b expected 0 0 0 11111",
                     read_data, sram_addr, ready, {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL reset_idle_ready: got %b expected 1", ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(1'b1, 1'b0, 32'd1032, 32'h0, st, wl, wp, ol, dq, cy, rd);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || st != 5) begin
            n_err++; $display("FAIL reissue_load: data %h stall %0d expected deadbeef 5", rd, st);
        end
    endtask

    task automatic test_both_enables;
        int st, wl, wp, ol, dq, cy;
        logic [31:0] rd;
        run_txn(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, st, wl, wp, ol, dq, cy, rd);
        n_cmp++;
        if (mem[2] !== 16'hF00D || mem[3] !== 16'hCAFE) begin
            n_err++; $display("FAIL both_mem: got %h %h expected f00d cafe", mem[2], mem[3]);
        end
        n_cmp++;
        if (rd !== 32'hDEADBEEF || ol != 0 || dq != 4) begin
            n_err++; $display("FAIL both_readdata: data %h oe_n low %0d dq_oe %0d expected deadbeef 0 4", rd, ol, dq);
        end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_store;
        test_load;
        test_back_to_back;
        test_reset_mid_load;
        test_both_enables;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
